// File: rtl/branch_repair_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_repair_arbiter_pkg
// Description : Shared widths, bit indices, FSM encodings and constants for
//               the branch repair arbiter and its BPU training buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_repair_arbiter_pkg;

    // Default datapath widths
    localparam int VADDR_W = 32;   // virtual address width
    localparam int CKPT_W  = 8;    // ALL_CHECKPOINT payload width
    localparam int ACT_W   = 4;    // repair-action width

    // Bit of the repair action that marks a request as needing a repair
    localparam int NEED_REPAIR = 0;

    // Sequential fetch after a not-taken branch skips the delay slot
    localparam int DELAY_SLOT_OFFSET = 8;

    // Restore counter width, large enough for REPAIR_CYCLES up to 15
    localparam int CNT_W = 4;

    // Repair FSM encodings
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REPAIR = 1'b1;

endpackage : branch_repair_arbiter_pkg
`default_nettype wire

// File: rtl/branch_repair_arbiter_bpu_update_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_repair_arbiter_bpu_update_buffer
// Description : One-entry valid/ready register holding a BPU training record.
//               A load in the same cycle the consumer accepts replaces the
//               entry and keeps valid asserted.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               load              - capture load_* into the entry
//               load_vaddr/dest/take - new training record
//               ready             - consumer accepts the current entry
//               valid             - entry present
//               vaddr/dest/take   - current training record (stable while valid)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_repair_arbiter_bpu_update_buffer #(
    parameter int VADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [VADDR_W-1:0] load_vaddr,
    input  logic [VADDR_W-1:0] load_dest,
    input  logic               load_take,
    input  logic               ready,
    output logic               valid,
    output logic [VADDR_W-1:0] vaddr,
    output logic [VADDR_W-1:0] dest,
    output logic               take
);

    logic               r_valid;
    logic [VADDR_W-1:0] r_vaddr;
    logic [VADDR_W-1:0] r_dest;
    logic               r_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_vaddr <= '0;
            r_dest  <= '0;
            r_take  <= 1'b0;
        end else if (load) begin
            // A new record always wins, even over a same-cycle accept
            r_valid <= 1'b1;
            r_vaddr <= load_vaddr;
            r_dest  <= load_dest;
            r_take  <= load_take;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign vaddr = r_vaddr;
    assign dest  = r_dest;
    assign take  = r_take;

endmodule : branch_repair_arbiter_bpu_update_buffer
`default_nettype wire

// File: rtl/branch_repair_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : branch_repair_arbiter
// Description : Arbitrates frontend redirects between the CP0 exception
//               flush, the second-stage branch amend (SBA) and the first
//               branch amend (FBA). Sequences the multi-cycle GHR/RAS
//               checkpoint restore and feeds a one-entry BPU training buffer.
// Ports       : clk, rst                  - clock, async active-high reset
//               exc_req_i/exc_target_i    - exception flush and vector
//               sba_* / fba_*             - branch amend request groups
//               sba_grant_o/fba_grant_o   - one-cycle accept pulses
//               redirect_valid_o/pc_o     - one-cycle fetch redirect
//               busy_o                    - fetch stall during restore
//               ckpt_restore_valid_o, ckpt_restore_o, action_o - restore strobe
//               bpu_upd_*                 - training entry, valid/ready
// Revision    : 1.0 - initial release
// ============================================================================
module branch_repair_arbiter
    import branch_repair_arbiter_pkg::*;
#(
    parameter int VADDR_W       = 32,
    parameter int CKPT_W        = 8,
    parameter int ACT_W         = 4,
    parameter int REPAIR_CYCLES = 2    // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_req_i,
    input  logic [VADDR_W-1:0] exc_target_i,
    input  logic               sba_req_i,
    input  logic [VADDR_W-1:0] sba_vaddr_i,
    input  logic [VADDR_W-1:0] sba_dest_i,
    input  logic               sba_take_i,
    input  logic [CKPT_W-1:0]  sba_ckpt_i,
    input  logic [ACT_W-1:0]   sba_action_i,
    input  logic               fba_req_i,
    input  logic [VADDR_W-1:0] fba_vaddr_i,
    input  logic [VADDR_W-1:0] fba_dest_i,
    input  logic               fba_take_i,
    input  logic [CKPT_W-1:0]  fba_ckpt_i,
    input  logic [ACT_W-1:0]   fba_action_i,
    output logic               sba_grant_o,
    output logic               fba_grant_o,
    output logic               redirect_valid_o,
    output logic [VADDR_W-1:0] redirect_pc_o,
    output logic               busy_o,
    output logic               ckpt_restore_valid_o,
    output logic [CKPT_W-1:0]  ckpt_restore_o,
    output logic [ACT_W-1:0]   action_o,
    output logic               bpu_upd_valid_o,
    input  logic               bpu_upd_ready_i,
    output logic [VADDR_W-1:0] bpu_upd_vaddr_o,
    output logic [VADDR_W-1:0] bpu_upd_dest_o,
    output logic               bpu_upd_take_o
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(REPAIR_CYCLES - 1);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_buf_can_load;
    logic               w_grant_ok;
    logic               w_sba_elig;
    logic               w_fba_elig;
    logic               w_sba_grant;
    logic               w_fba_grant;
    logic               w_grant;

    logic [VADDR_W-1:0] w_win_vaddr;
    logic [VADDR_W-1:0] w_win_dest;
    logic               w_win_take;
    logic [CKPT_W-1:0]  w_win_ckpt;
    logic [ACT_W-1:0]   w_win_action;
    logic [VADDR_W-1:0] w_win_pc;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // The buffer can take a new record if it is empty or being drained now.
    assign w_buf_can_load = ~bpu_upd_valid_o | bpu_upd_ready_i;

    // rst gates the combinational grants so every output is low in reset.
    assign w_grant_ok = ~rst & (r_state == ST_IDLE) & ~exc_req_i & w_buf_can_load;

    assign w_sba_elig = sba_req_i & sba_action_i[NEED_REPAIR];
    assign w_fba_elig = fba_req_i & fba_action_i[NEED_REPAIR];

    // FBA is younger than SBA and gets squashed by the SBA redirect.
    assign w_sba_grant = w_grant_ok & w_sba_elig;
    assign w_fba_grant = w_grant_ok & w_fba_elig & ~w_sba_elig;
    assign w_grant     = w_sba_grant | w_fba_grant;

    assign sba_grant_o = w_sba_grant;
    assign fba_grant_o = w_fba_grant;

    always_comb begin
        w_win_vaddr  = fba_vaddr_i;
        w_win_dest   = fba_dest_i;
        w_win_take   = fba_take_i;
        w_win_ckpt   = fba_ckpt_i;
        w_win_action = fba_action_i;
        if (w_sba_grant) begin
            w_win_vaddr  = sba_vaddr_i;
            w_win_dest   = sba_dest_i;
            w_win_take   = sba_take_i;
            w_win_ckpt   = sba_ckpt_i;
            w_win_action = sba_action_i;
        end
    end

    // Not-taken resumes after the delay slot; the add wraps modulo 2^VADDR_W.
    assign w_win_pc = w_win_take ? w_win_dest
                                 : (w_win_vaddr + VADDR_W'(DELAY_SLOT_OFFSET));

    // ------------------------------------------------------------------
    // Repair FSM: grant at T occupies T+1..T+REPAIR_CYCLES
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (exc_req_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= ST_REPAIR;
                        r_cnt   <= C_CNT_LOAD;
                    end
                end
                ST_REPAIR: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy_o = (r_state == ST_REPAIR);

    // ------------------------------------------------------------------
    // Redirect and restore strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_o     <= 1'b0;
            redirect_pc_o        <= '0;
            ckpt_restore_valid_o <= 1'b0;
            ckpt_restore_o       <= '0;
            action_o             <= '0;
        end else begin
            redirect_valid_o     <= 1'b0;
            ckpt_restore_valid_o <= 1'b0;
            if (exc_req_i) begin
                redirect_valid_o <= 1'b1;
                redirect_pc_o    <= exc_target_i;
            end else if (w_grant) begin
                redirect_valid_o     <= 1'b1;
                redirect_pc_o        <= w_win_pc;
                ckpt_restore_valid_o <= 1'b1;
                ckpt_restore_o       <= w_win_ckpt;
                action_o             <= w_win_action;
            end
        end
    end

    // ------------------------------------------------------------------
    // BPU training buffer (kept across exception flushes)
    // ------------------------------------------------------------------
    branch_repair_arbiter_bpu_update_buffer #(
        .VADDR_W (VADDR_W)
    ) u_bpu_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (w_grant),
        .load_vaddr (w_win_vaddr),
        .load_dest  (w_win_dest),
        .load_take  (w_win_take),
        .ready      (bpu_upd_ready_i),
        .valid      (bpu_upd_valid_o),
        .vaddr      (bpu_upd_vaddr_o),
        .dest       (bpu_upd_dest_o),
        .take       (bpu_upd_take_o)
    );

endmodule : branch_repair_arbiter
`default_nettype wire

// File: tb/tb_branch_repair_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_repair_arbiter
// Description : Directed scoreboard bench for branch_repair_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_repair_arbiter;

    localparam int VW = 32;
    localparam int CW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          exc_req;
    logic [VW-1:0] exc_target;
    logic          sba_req, sba_take, fba_req, fba_take;
    logic [VW-1:0] sba_vaddr, sba_dest, fba_vaddr, fba_dest;
    logic [CW-1:0] sba_ckpt, fba_ckpt;
    logic [AW-1:0] sba_action, fba_action;
    logic          sba_grant, fba_grant;
    logic          redirect_valid;
    logic [VW-1:0] redirect_pc;
    logic          busy;
    logic          restore_valid;
    logic [CW-1:0] restore_ckpt;
    logic [AW-1:0] action;
    logic          bpu_valid, bpu_ready, bpu_take;
    logic [VW-1:0] bpu_vaddr, bpu_dest;

    int n_cmp = 0;
    int n_bad = 0;

    logic [VW-1:0]        redir_q[$];
    logic [CW+AW-1:0]     rest_q[$];
    logic [2*VW:0]        bpu_q[$];

    branch_repair_arbiter #(
        .VADDR_W(VW), .CKPT_W(CW), .ACT_W(AW), .REPAIR_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .exc_req_i(exc_req), .exc_target_i(exc_target),
        .sba_req_i(sba_req), .sba_vaddr_i(sba_vaddr), .sba_dest_i(sba_dest),
        .sba_take_i(sba_take), .sba_ckpt_i(sba_ckpt), .sba_action_i(sba_action),
        .fba_req_i(fba_req), .fba_vaddr_i(fba_vaddr), .fba_dest_i(fba_dest),
        .fba_take_i(fba_take), .fba_ckpt_i(fba_ckpt), .fba_action_i(fba_action),
        .sba_grant_o(sba_grant), .fba_grant_o(fba_grant),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .busy_o(busy),
        .ckpt_restore_valid_o(restore_valid), .ckpt_restore_o(restore_ckpt),
        .action_o(action),
        .bpu_upd_valid_o(bpu_valid), .bpu_upd_ready_i(bpu_ready),
        .bpu_upd_vaddr_o(bpu_vaddr), .bpu_upd_dest_o(bpu_dest),
        .bpu_upd_take_o(bpu_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sba(input logic req, input logic [VW-1:0] va, input logic [VW-1:0] de,
                           input logic tk, input logic [CW-1:0] ck, input logic [AW-1:0] ac);
        sba_req = req; sba_vaddr = va; sba_dest = de;
        sba_take = tk; sba_ckpt = ck; sba_action = ac;
    endtask

    task automatic set_fba(input logic req, input logic [VW-1:0] va, input logic [VW-1:0] de,
                           input logic tk, input logic [CW-1:0] ck, input logic [AW-1:0] ac);
        fba_req = req; fba_vaddr = va; fba_dest = de;
        fba_take = tk; fba_ckpt = ck; fba_action = ac;
    endtask

    task automatic expect_grant(input logic [VW-1:0] pc, input logic [CW-1:0] ck,
                                input logic [AW-1:0] ac, input logic [VW-1:0] va,
                                input logic [VW-1:0] de, input logic tk, input logic keep_bpu);
        redir_q.push_back(pc);
        rest_q.push_back({ck, ac});
        if (keep_bpu) bpu_q.push_back({va, de, tk});
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (redirect_valid) begin
                    if (redir_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL redirect_unexpected: got pc 0x%0h expected none at %0t", redirect_pc, $time);
                    end else begin
                        check("redirect_pc", 96'(redirect_pc), 96'(redir_q.pop_front()));
                    end
                end
                if (restore_valid) begin
                    if (rest_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL restore_unexpected: got ckpt 0x%0h expected none at %0t", restore_ckpt, $time);
                    end else begin
                        check("restore_ckpt_action", 96'({restore_ckpt, action}), 96'(rest_q.pop_front()));
                    end
                end
                if (bpu_valid && bpu_ready) begin
                    if (bpu_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL bpu_unexpected: got vaddr 0x%0h expected none at %0t", bpu_vaddr, $time);
                    end else begin
                        check("bpu_entry", 96'({bpu_vaddr, bpu_dest, bpu_take}), 96'(bpu_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; exc_req = 1'b0; exc_target = '0; bpu_ready = 1'b1;
        set_sba(0, 0, 0, 0, 0, 0);
        set_fba(0, 0, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_redirect_valid", 96'(redirect_valid), 96'(0));
        check("rst_busy",           96'(busy),           96'(0));
        check("rst_restore_valid",  96'(restore_valid),  96'(0));
        check("rst_bpu_valid",      96'(bpu_valid),      96'(0));
        check("rst_redirect_pc",    96'(redirect_pc),    96'(0));
        step(); step();
        rst = 1'b0;

        // ---------------- 1: taken SBA ----------------
        set_sba(1, 32'h8000_1000, 32'h8000_2000, 1, 8'h5A, 4'h1);
        @(negedge clk);
        check("t1_sba_grant", 96'(sba_grant), 96'(1));
        check("t1_fba_grant", 96'(fba_grant), 96'(0));
        expect_grant(32'h8000_2000, 8'h5A, 4'h1, 32'h8000_1000, 32'h8000_2000, 1, 1);
        step();
        set_sba(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_busy_1",      96'(busy),      96'(1));
        check("t1_bpu_valid",   96'(bpu_valid), 96'(1));
        step();
        @(negedge clk);
        check("t1_busy_2",      96'(busy),      96'(1));
        step();
        @(negedge clk);
        check("t1_busy_end",    96'(busy),      96'(0));

        // ------ 2: SBA and FBA together, not-taken wrap; FBA held ------
        step();
        set_sba(1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 8'hA1, 4'h1);
        set_fba(1, 32'h0040_0010, 32'h0040_0800, 0, 8'h33, 4'h3);
        @(negedge clk);
        check("t2_sba_grant", 96'(sba_grant), 96'(1));
        check("t2_fba_grant", 96'(fba_grant), 96'(0));
        expect_grant(32'h0000_0004, 8'hA1, 4'h1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 1);
        step();
        set_sba(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_fba_held_in_repair", 96'(fba_grant), 96'(0));
            step();
        end
        @(negedge clk);
        check("t2_fba_grant_after_repair", 96'(fba_grant), 96'(1));
        expect_grant(32'h0040_0018, 8'h33, 4'h3, 32'h0040_0010, 32'h0040_0800, 0, 1);
        step();
        set_fba(0, 0, 0, 0, 0, 0);
        step(); step();

        // ------ 3: exception in the first REPAIR cycle ------
        bpu_ready = 1'b0;
        set_sba(1, 32'h8000_3000, 32'h8000_4000, 1, 8'h44, 4'h1);
        @(negedge clk);
        check("t3_sba_grant", 96'(sba_grant), 96'(1));
        expect_grant(32'h8000_4000, 8'h44, 4'h1, 32'h8000_3000, 32'h8000_4000, 1, 1);
        step();
        set_sba(0, 0, 0, 0, 0, 0);
        exc_req = 1'b1; exc_target = 32'hBFC0_0380;
        redir_q.push_back(32'hBFC0_0380);
        @(negedge clk);
        check("t3_busy_repair", 96'(busy), 96'(1));
        step();
        exc_req = 1'b0; exc_target = '0;
        @(negedge clk);
        check("t3_busy_after_exc",    96'(busy),          96'(0));
        check("t3_no_restore_on_exc", 96'(restore_valid), 96'(0));
        check("t3_bpu_kept",          96'(bpu_valid),     96'(1));
        check("t3_bpu_vaddr_stable",  96'(bpu_vaddr),     96'(32'h8000_3000));
        step();

        // ------ 4: buffer blocked, grant lands with ready ------
        set_sba(1, 32'h8000_5000, 32'h8000_6000, 0, 8'h77, 4'h5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_blocked_grant", 96'(sba_grant), 96'(0));
            check("t4_blocked_bpu",   96'(bpu_valid), 96'(1));
            step();
        end
        bpu_ready = 1'b1;
        @(negedge clk);
        check("t4_grant_on_ready", 96'(sba_grant), 96'(1));
        expect_grant(32'h8000_5008, 8'h77, 4'h5, 32'h8000_5000, 32'h8000_6000, 0, 1);
        step();
        bpu_ready = 1'b0;
        set_sba(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t4_reload_valid", 96'(bpu_valid), 96'(1));
        check("t4_reload_vaddr", 96'(bpu_vaddr), 96'(32'h8000_5000));
        step();
        bpu_ready = 1'b1;
        step(); step();

        // ------ 5: action[0]=0 never granted ------
        set_sba(1, 32'h8000_9000, 32'h8000_A000, 1, 8'h11, 4'h2);
        set_fba(1, 32'h8000_9100, 32'h8000_A100, 1, 8'h22, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_sba_no_grant", 96'(sba_grant),      96'(0));
            check("t5_fba_no_grant", 96'(fba_grant),      96'(0));
            check("t5_no_redirect",  96'(redirect_valid), 96'(0));
            step();
        end
        set_sba(0, 0, 0, 0, 0, 0);
        set_fba(0, 0, 0, 0, 0, 0);
        step();

        // ------ 6: asynchronous reset mid-REPAIR ------
        bpu_ready = 1'b0;
        set_sba(1, 32'h8000_7000, 32'h8000_8000, 1, 8'h99, 4'h1);
        @(negedge clk);
        check("t6_sba_grant", 96'(sba_grant), 96'(1));
        expect_grant(32'h8000_8000, 8'h99, 4'h1, 32'h8000_7000, 32'h8000_8000, 1, 0);
        step();
        set_sba(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t6_busy_before_rst", 96'(busy), 96'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",           96'(busy),           96'(0));
        check("t6_rst_redirect_valid", 96'(redirect_valid), 96'(0));
        check("t6_rst_restore_valid",  96'(restore_valid),  96'(0));
        check("t6_rst_bpu_valid",      96'(bpu_valid),      96'(0));
        step();
        rst = 1'b0;
        bpu_ready = 1'b1;
        set_sba(1, 32'h0000_0010, 32'h0000_0F00, 0, 8'hC3, 4'h1);
        @(negedge clk);
        check("t6_idle_after_rst", 96'(busy),      96'(0));
        check("t6_grant_after_rst", 96'(sba_grant), 96'(1));
        expect_grant(32'h0000_0018, 8'hC3, 4'h1, 32'h0000_0010, 32'h0000_0F00, 0, 1);
        step();
        set_sba(0, 0, 0, 0, 0, 0);
        step(); step(); step();

        // ------ drain check ------
        check("redir_q_drained", 96'(redir_q.size()), 96'(0));
        check("rest_q_drained",  96'(rest_q.size()),  96'(0));
        check("bpu_q_drained",   96'(bpu_q.size()),   96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_branch_repair_arbiter
`default_nettype wire
